// File: rtl/hall_pkg.sv
// Shared types and constants for the hall-sensor column timer.
package hall_pkg;
    localparam int PER_W = 32;

    typedef enum logic [1:0] {IDLE, MEAS, RUN, STALL} state_t;
endpackage

// File: rtl/hall_debounce.sv
// Hall input conditioning: 2-FF synchroniser, DEB_LEN-sample filter and
// falling-edge detector producing a one-cycle index pulse.
module hall_debounce #(
    parameter int DEB_LEN = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hall_raw,
    output logic index
);
    localparam int CW = $clog2(DEB_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic          filt;
    logic [CW-1:0] run;

    // run counts consecutive synced samples that disagree with the filtered level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            filt  <= 1'b1;
            run   <= '0;
            index <= 1'b0;
        end else begin
            sync1 <= hall_raw;
            sync2 <= sync1;
            index <= 1'b0;
            if (sync2 == filt) begin
                run <= '0;
            end else if (run == CW'(DEB_LEN - 1)) begin
                run   <= '0;
                filt  <= sync2;
                index <= ~sync2;
            end else begin
                run <= run + CW'(1);
            end
        end
    end
endmodule

// File: rtl/hall_column_timer.sv
// Revolution period measurement and column strobe generation for the POV display.
// Optional HALL_OFFSET_EN rotates col_idx by COL_OFFSET.
module hall_column_timer
    import hall_pkg::*;
#(
    parameter int COLS_LOG2    = 8,
    parameter int DEB_LEN      = 16,
    parameter int MIN_PERIOD   = 100000,
    parameter int STALL_CYCLES = 200000000,
    parameter int COL_OFFSET   = 0
) (
    input  logic                 CLK_100M,
    input  logic                 RST_N,
    input  logic                 HAL249,
    output logic                 col_tick,
    output logic [COLS_LOG2-1:0] col_idx,
    output logic                 rev_tick,
    output logic [PER_W-1:0]     rev_period,
    output logic                 period_valid,
    output logic                 stalled
);
    localparam logic [PER_W:0]       MIN_P    = (PER_W + 1)'(MIN_PERIOD);
    localparam logic [PER_W-1:0]     STALL_P  = PER_W'(STALL_CYCLES);
    localparam logic [COLS_LOG2-1:0] LAST_COL = '1;
`ifdef HALL_OFFSET_EN
    localparam logic [COLS_LOG2-1:0] OFF = COLS_LOG2'(COL_OFFSET);
`else
    // rotation disabled: the offset contributes nothing
    localparam logic [COLS_LOG2-1:0] OFF = COLS_LOG2'(COL_OFFSET * 0);
`endif

    logic                 index;
    state_t               state;
    state_t               state_next;
    logic [PER_W-1:0]     cnt;
    logic [PER_W:0]       cnt_inc;
    logic                 len_ok;
    logic                 at_stall;
    logic [PER_W-1:0]     cp_raw;
    logic [PER_W-1:0]     cp_load;
    logic [PER_W-1:0]     col_period;
    logic [PER_W-1:0]     col_cnt;
    logic [COLS_LOG2-1:0] raw_idx;
    logic                 accept;
    logic                 restart;
    logic                 enter_stall;
    logic                 run_cols;

    hall_debounce #(.DEB_LEN(DEB_LEN)) u_deb (
        .clk     (CLK_100M),
        .rst_n   (RST_N),
        .hall_raw(HAL249),
        .index   (index)
    );

    assign cnt_inc  = {1'b0, cnt} + (PER_W + 1)'(1);
    assign len_ok   = (cnt_inc >= MIN_P);
    assign at_stall = (cnt == STALL_P);
    assign cp_raw   = cnt_inc[PER_W-1:0] >> COLS_LOG2;
    assign cp_load  = (cp_raw == '0) ? PER_W'(1) : cp_raw;

    always_ff @(posedge CLK_100M or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    // an acceptable index takes priority over reaching the stall limit
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (index) state_next = MEAS;
            MEAS:  if (index && len_ok) state_next = RUN;
                   else if (at_stall)   state_next = STALL;
            RUN:   if (!(index && len_ok) && at_stall) state_next = STALL;
            STALL: if (index) state_next = MEAS;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept      = 1'b0;
        restart     = 1'b0;
        enter_stall = 1'b0;
        run_cols    = 1'b0;
        case (state)
            IDLE, STALL: restart = index;
            MEAS, RUN: begin
                accept      = index && len_ok;
                enter_stall = !accept && at_stall;
                run_cols    = (state == RUN) && !accept && !enter_stall;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_100M or negedge RST_N) begin
        if (!RST_N) begin
            cnt          <= '0;
            rev_period   <= '0;
            col_period   <= '0;
            col_cnt      <= '0;
            raw_idx      <= '0;
            col_idx      <= '0;
            col_tick     <= 1'b0;
            rev_tick     <= 1'b0;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            col_tick <= 1'b0;
            rev_tick <= accept;

            if (accept || restart)  cnt <= '0;
            else if (!at_stall)     cnt <= cnt + PER_W'(1);

            if (restart)     stalled <= 1'b0;
            if (enter_stall) begin
                stalled      <= 1'b1;
                period_valid <= 1'b0;
            end

            if (accept) begin
                rev_period   <= cnt_inc[PER_W-1:0];
                col_period   <= cp_load;
                period_valid <= 1'b1;
                col_cnt      <= '0;
                raw_idx      <= '0;
                col_idx      <= OFF;
                col_tick     <= 1'b1;
            end else if (run_cols) begin
                // after the last column the slot counter keeps cycling silently
                if (col_cnt == col_period - PER_W'(1)) begin
                    col_cnt <= '0;
                    if (raw_idx != LAST_COL) begin
                        raw_idx  <= raw_idx + COLS_LOG2'(1);
                        col_idx  <= raw_idx + COLS_LOG2'(1) + OFF;
                        col_tick <= 1'b1;
                    end
                end else begin
                    col_cnt <= col_cnt + PER_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_hall_column_timer.sv
// Directed self-checking bench for hall_column_timer (small-parameter build).
module tb_hall_column_timer;
    import hall_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hal = 1'b1;
    logic       col_tick;
    logic [2:0] col_idx;
    logic       rev_tick;
    logic [31:0] rev_period;
    logic       period_valid;
    logic       stalled;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int tq[$];
    int iq[$];
    int rq[$];

    hall_column_timer #(
        .COLS_LOG2(3), .DEB_LEN(4), .MIN_PERIOD(64), .STALL_CYCLES(5000), .COL_OFFSET(5)
    ) dut (
        .CLK_100M(clk), .RST_N(rst_n), .HAL249(hal),
        .col_tick(col_tick), .col_idx(col_idx), .rev_tick(rev_tick),
        .rev_period(rev_period), .period_valid(period_valid), .stalled(stalled)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (col_tick) begin
            tq.push_back(cyc);
            iq.push_back(int'(col_idx));
        end
        if (rev_tick) rq.push_back(cyc);
    end

    function automatic int ex(input int r);
`ifdef HALL_OFFSET_EN
        return (r + 5) % 8;
`else
        return r;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // hold the hall pin at v for n clock edges; returns 1 time unit after an edge
    task automatic drive(input logic v, input int n);
        hal = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int period);
        drive(1'b0, 20);
        drive(1'b1, period - 20);
    endtask

    task automatic clear_logs();
        tq.delete();
        iq.delete();
        rq.delete();
    endtask

    task automatic check_full_rev(input string tag, input int spacing);
        check({tag, "_ntick"}, 64'(tq.size()), 64'd8);
        check({tag, "_nrev"}, 64'(rq.size()), 64'd1);
        if (tq.size() == 8) begin
            for (int i = 0; i < 8; i++) check({tag, "_idx"}, 64'(iq[i]), 64'(ex(i)));
            for (int i = 1; i < 8; i++) check({tag, "_gap"}, 64'(tq[i] - tq[i-1]), 64'(spacing));
        end
    endtask

    initial begin
        // 1: reset and idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 1000);
        check("rst_col_tick", 64'(col_tick), 64'd0);
        check("rst_col_idx", 64'(col_idx), 64'd0);
        check("rst_rev_tick", 64'(rev_tick), 64'd0);
        check("rst_rev_period", 64'(rev_period), 64'd0);
        check("rst_valid", 64'(period_valid), 64'd0);
        check("rst_stalled", 64'(stalled), 64'd0);
        check("rst_state", 64'(dut.state), 64'(IDLE));

        // 2: two clean indexes 800 apart
        pulse(800);
        check("meas_state", 64'(dut.state), 64'(MEAS));
        check("meas_no_ticks", 64'(tq.size()), 64'd0);
        clear_logs();
        pulse(800);
        check("run_period", 64'(rev_period), 64'd800);
        check("run_valid", 64'(period_valid), 64'd1);
        check_full_rev("rev2", 100);
        if (rq.size() == 1 && tq.size() > 0) check("rev_col_same_cycle", 64'(rq[0]), 64'(tq[0]));
        check("no_wrap_idx", 64'(col_idx), 64'(ex(7)));

        // 3: short index 30 cycles after a valid one, then a 3-cycle glitch
        clear_logs();
        drive(1'b0, 20);
        drive(1'b1, 10);
        drive(1'b0, 10);
        drive(1'b1, 260);
        drive(1'b0, 3);
        drive(1'b1, 497);
        check("glitch_period", 64'(rev_period), 64'd800);
        check_full_rev("rev3", 100);

        // 4: period drops to 640 while col_period is still 100
        clear_logs();
        pulse(640);
        check("short_idx_ignored", 64'(rev_period), 64'd800);
        pulse(640);
        check("drop_period", 64'(rev_period), 64'd640);
        check("drop_ntick", 64'(tq.size()), 64'd15);
        check("drop_nrev", 64'(rq.size()), 64'd2);
        if (rq.size() == 2) check("drop_rev_gap", 64'(rq[1] - rq[0]), 64'd640);
        if (tq.size() == 15) begin
            check("drop_idx6", 64'(iq[6]), 64'(ex(6)));
            check("drop_idx_reload", 64'(iq[7]), 64'(ex(0)));
            check("drop_gap_idx", 64'(tq[7] - tq[6]), 64'd40);
            check("drop_new_gap", 64'(tq[8] - tq[7]), 64'd80);
            check("drop_idx_last", 64'(iq[14]), 64'(ex(7)));
            check("drop_last_gap", 64'(tq[14] - tq[7]), 64'd560);
        end

        // 5: stall boundary (cnt reaches 5000 one edge before stall is flagged)
        drive(1'b1, 4367);
        check("pre_stall", 64'(stalled), 64'd0);
        check("pre_stall_valid", 64'(period_valid), 64'd1);
        drive(1'b1, 1);
        check("stall_flag", 64'(stalled), 64'd1);
        check("stall_valid", 64'(period_valid), 64'd0);
        check("stall_state", 64'(dut.state), 64'(STALL));
        drive(1'b1, 1632);
        check("stall_hold", 64'(stalled), 64'd1);
        check("stall_period_held", 64'(rev_period), 64'd640);
        pulse(800);
        check("resume_stalled", 64'(stalled), 64'd0);
        check("resume_state", 64'(dut.state), 64'(MEAS));
        check("resume_valid", 64'(period_valid), 64'd0);
        clear_logs();
        pulse(800);
        check("resume_period", 64'(rev_period), 64'd800);
        check("resume_run_valid", 64'(period_valid), 64'd1);
        check_full_rev("rev_resume", 100);

        // reset mid-operation is immediate
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_idx", 64'(col_idx), 64'd0);
        check("mid_rst_period", 64'(rev_period), 64'd0);
        check("mid_rst_valid", 64'(period_valid), 64'd0);
        check("mid_rst_state", 64'(dut.state), 64'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
